// File: rtl/demux_queue_16.sv
// demux_queue_16: steers one 16-bit word stream into two independent
// valid/ready output queues (A when in_sel = 0, B when in_sel = 1).
// A stalled consumer only back-pressures words aimed at its own queue.
// Optional build macro DEMUX_COUNT_EN adds per-queue push counters
// (cnt_a, cnt_b) that wrap at 16 bits.

// Small synchronous FIFO used for each destination queue.
module demux_queue_16_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    // Storage write: clear everything on reset, otherwise write at the tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer bookkeeping; DEPTH is a power of two so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy tracking; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Head of queue and status flags derived from the registered state.
    always_comb begin
        rdata = mem[rd_ptr];
        valid = (count != '0);
        full  = (count == (PTR_W+1)'(DEPTH));
    end

endmodule

// Top level: routing, back-pressure and the optional push counters.
module demux_queue_16 #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready
`ifdef DEMUX_COUNT_EN
    ,
    output logic [15:0]      cnt_a,
    output logic [15:0]      cnt_b
`endif
);

    logic full_a;
    logic full_b;
    logic push_a;
    logic push_b;
    logic pop_a;
    logic pop_b;

    // Back-pressure follows only the selected queue's full flag, so the
    // producer sees a stable ready that never depends on in_valid or on
    // the consumers' ready inputs.
    always_comb begin
        in_ready = in_sel ? !full_b : !full_a;
        push_a   = in_valid && in_ready && !in_sel;
        push_b   = in_valid && in_ready &&  in_sel;
        pop_a    = a_valid && a_ready;
        pop_b    = b_valid && b_ready;
    end

    demux_queue_16_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_queue_a (
        .clk   (clk),
        .rst   (rst),
        .push  (push_a),
        .wdata (in_data),
        .pop   (pop_a),
        .rdata (a_data),
        .valid (a_valid),
        .full  (full_a)
    );

    demux_queue_16_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_queue_b (
        .clk   (clk),
        .rst   (rst),
        .push  (push_b),
        .wdata (in_data),
        .pop   (pop_b),
        .rdata (b_data),
        .valid (b_valid),
        .full  (full_b)
    );

`ifdef DEMUX_COUNT_EN
    // Per-queue count of accepted words, free-running modulo 2^16.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (push_a) begin
                cnt_a <= cnt_a + 16'd1;
            end
            if (push_b) begin
                cnt_b <= cnt_b + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_demux_queue_16.sv
// tb_demux_queue_16: directed self-checking bench for demux_queue_16.
// Define DEMUX_COUNT_EN for both bench and design to exercise the counters.

module tb_demux_queue_16;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_data;
    logic        a_valid;
    logic        a_ready;
    logic [15:0] b_data;
    logic        b_valid;
    logic        b_ready;
`ifdef DEMUX_COUNT_EN
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;
`endif

    int assertCount;
    int failCount;

    demux_queue_16 dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready)
`ifdef DEMUX_COUNT_EN
        ,
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b)
`endif
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached (observed hang, required finish)");
        $fatal(1, "[TB] watchdog expired");
    end

    // A word presented for routing must have a known destination.
    always @(posedge clk) begin
        if (!rst && in_valid) begin
            assert (!$isunknown(in_sel))
                else $error("[TB] in_sel unknown while in_valid");
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%04h, expected 0x%04h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic s,
                                 input logic [15:0] d, input logic ar, input logic br);
        rst      = r;
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
        #1;
    endtask

    // Advance past one rising edge and settle away from it.
    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h5555, 1'b0, 1'b0);

        // Reset held two cycles with a word offered: nothing may be queued.
        for (int i = 0; i < 2; i++) begin
            waitCycle();
            checkOutput("rst_a_valid", 16'(a_valid), 16'd0);
            checkOutput("rst_b_valid", 16'(b_valid), 16'd0);
            checkOutput("rst_a_data",  a_data, 16'h0000);
            checkOutput("rst_b_data",  b_data, 16'h0000);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        waitCycle();
        checkOutput("rel_in_ready_a", 16'(in_ready), 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        checkOutput("rel_in_ready_b", 16'(in_ready), 16'd1);
        checkOutput("rel_a_valid", 16'(a_valid), 16'd0);

        // Basic routing with both consumers ready.
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b1);
        waitCycle();
        checkOutput("route_a_valid", 16'(a_valid), 16'd1);
        checkOutput("route_a_data",  a_data, 16'h1234);
        checkOutput("route_b_idle",  16'(b_valid), 16'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'hABCD, 1'b1, 1'b1);
        waitCycle();
        checkOutput("route_a_once",  16'(a_valid), 16'd0);
        checkOutput("route_b_valid", 16'(b_valid), 16'd1);
        checkOutput("route_b_data",  b_data, 16'hABCD);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
        waitCycle();
        checkOutput("route_b_once",  16'(b_valid), 16'd0);

        // Fill A while its consumer stalls; B must keep flowing.
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b1);
        waitCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b1);
        waitCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0009, 1'b0, 1'b1);
        checkOutput("fullA_in_ready", 16'(in_ready), 16'd0);
        checkOutput("fullA_head",     a_data, 16'h0001);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 1'b1);
        checkOutput("fullA_b_ready",  16'(in_ready), 16'd1);
        waitCycle();
        checkOutput("fullA_b_valid",  16'(b_valid), 16'd1);
        checkOutput("fullA_b_data",   b_data, 16'h0003);
        checkOutput("fullA_head_kept", a_data, 16'h0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        waitCycle();
        checkOutput("drain_a_valid1", 16'(a_valid), 16'd1);
        checkOutput("drain_a_data2",  a_data, 16'h0002);
        checkOutput("drain_b_empty",  16'(b_valid), 16'd0);
        waitCycle();
        checkOutput("drain_a_empty",  16'(a_valid), 16'd0);

        // Full queue with simultaneous push and pop: only the pop happens.
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0011, 1'b0, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0022, 1'b0, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0033, 1'b1, 1'b0);
        checkOutput("pp_blocked",    16'(in_ready), 16'd0);
        waitCycle();
        checkOutput("pp_head",       a_data, 16'h0022);
        checkOutput("pp_ready_back", 16'(in_ready), 16'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0033, 1'b0, 1'b0);
        waitCycle();
        checkOutput("pp_head_kept",  a_data, 16'h0022);
        checkOutput("pp_full_again", 16'(in_ready), 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        waitCycle();
        checkOutput("pp_next_valid", 16'(a_valid), 16'd1);
        checkOutput("pp_next_data",  a_data, 16'h0033);
        waitCycle();
        checkOutput("pp_empty",      16'(a_valid), 16'd0);

        // Reset mid-stream discards every queued word.
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0A01, 1'b0, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0A02, 1'b0, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0B01, 1'b0, 1'b0);
        waitCycle();
        checkOutput("mid_a_loaded", 16'(a_valid), 16'd1);
        checkOutput("mid_b_loaded", 16'(b_valid), 16'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1);
        waitCycle();
        checkOutput("mid_a_cleared", 16'(a_valid), 16'd0);
        checkOutput("mid_b_cleared", 16'(b_valid), 16'd0);
        checkOutput("mid_a_data0",   a_data, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            waitCycle();
            checkOutput("mid_no_old_a", 16'(a_valid), 16'd0);
            checkOutput("mid_no_old_b", 16'(b_valid), 16'd0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h7777, 1'b0, 1'b0);
        waitCycle();
        checkOutput("mid_new_b_data", b_data, 16'h7777);

`ifdef DEMUX_COUNT_EN
        // Push counters: 70000 words to B wrap to 70000 - 65536 = 4464.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        waitCycle();
        checkOutput("cnt_rst_a", cnt_a, 16'd0);
        checkOutput("cnt_rst_b", cnt_b, 16'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h00C5, 1'b1, 1'b1);
        for (int i = 0; i < 70000; i++) begin
            waitCycle();
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
        waitCycle();
        checkOutput("cnt_b_wrap", cnt_b, 16'd4464);
        checkOutput("cnt_a_zero", cnt_a, 16'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/demux_queue_16.md
Name: demux_queue_16

Overview:
- Inverse of the 2:1 datapath mux: takes one 16-bit word stream and steers each word to one of two destinations, chosen by a per-word select bit.
- Each destination has its own small FIFO with a valid/ready handshake, so one stalled consumer does not block traffic to the other.
- Sits between a single producer, such as a writeback/result bus, and two consumers, such as the register-file write port and the memory-store path.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 2, entries per output queue; must be a power of two, 2..16.
- PTR_W, 1, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to route.
- in_sel  input  1  destination: 0 = port A, 1 = port B.
- in_valid  input  1  producer has a word this cycle.
- in_ready  output  1  word accepted this cycle if in_valid is also 1.
- a_data  output  WIDTH  head word of queue A.
- a_valid  output  1  queue A non-empty.
- a_ready  input  1  consumer A takes the head word.
- b_data  output  WIDTH  head word of queue B.
- b_valid  output  1  queue B non-empty.
- b_ready  input  1  consumer B takes the head word.

Behaviour:
- Reset and sampling: rst is synchronous and active-high, sampled on the rising edge of clk. It overrides all other activity in the same cycle.
- Reset state:
  - Both queues empty; all read/write pointers and occupancy counts are 0.
  - All storage entries cleared to 0.
  - a_valid = b_valid = 0.
  - a_data = b_data = 0.
  - in_ready = 1 after the first clock with rst low.
- Reset mid-operation: all queued words are discarded with no output handshake. A push or pop presented in the same cycle as rst has no effect.
- in_ready: combinational, equal to !full_A when in_sel = 0 and !full_B when in_sel = 1. It depends on in_sel but never on in_valid or on the out-side ready inputs.
- Push: occurs when in_valid & in_ready. in_data is written at the write pointer of the selected queue, that pointer increments and wraps modulo DEPTH, and the count increments.
- Pop (per queue): occurs when x_valid & x_ready. The read pointer increments and wraps modulo DEPTH, and the count decrements.
- x_data: always storage[read pointer]. Its value while x_valid = 0 is don't-care, except for the reset value.
- Latency: a word accepted at edge N appears on x_valid/x_data after edge N. There is no same-cycle bypass from in_data to x_data.
- Push and pop on the same queue in the same cycle:
  - Both happen and the count is unchanged.
  - On a full queue the push is blocked, because in_ready reflects full state at the start of the cycle. Only the pop happens.
  - On an empty queue only the push happens, because x_valid = 0.
- Independence: a push to one queue and pops on both queues may all occur in the same cycle.
- Full/empty flags: full = (count == DEPTH), empty = (count == 0). count is PTR_W+1 bits wide.
- Ordering: words to the same destination leave in acceptance order. No ordering is guaranteed between A and B.
- Illegal input: in_sel with X/Z while in_valid = 1 is illegal. Bench assertion only; no RTL handling.

Optional Feature:
- Macro: DEMUX_COUNT_EN.
- When defined:
  - Adds output ports cnt_a and cnt_b, each 16-bit.
  - Each counts pushes into its queue, increments by 1 per accepted word, and wraps 0xFFFF -> 0x0000.
  - Both reset to 0 on rst.
  - Both are registered and update on the edge of the push.
- When undefined: the ports and counters are absent, with no other behavioural difference.

Test Plan:
- Reset: hold rst for 2 cycles with in_valid = 1 -> a_valid = b_valid = 0, a_data = b_data = 0x0000, nothing queued; in_ready = 1 after release.
- Basic routing: push 0x1234 with sel = 0, then 0xABCD with sel = 1, with a_ready = b_ready = 1 -> a_valid one cycle after the first push with a_data = 0x1234; b_data = 0xABCD one cycle after the second push; each word is seen exactly once.
- Full A with B flowing: a_ready = 0, push 0x0001 and 0x0002 to A -> in_ready = 0 while sel = 0; switch sel = 1 and push 0x0003 -> accepted, b_data = 0x0003; raise a_ready -> A drains 0x0001 then 0x0002, in order.
- Full queue, push and pop in the same cycle: A full, a_ready = 1, in_valid = 1, sel = 0 -> only the pop happens; on the next cycle in_ready = 1 and the push succeeds; the queue contents stay in order.
- Reset mid-stream: A holds 2 words and B holds 1, assert rst -> both valids go to 0 the next cycle; after release, the old words never appear.
- With DEMUX_COUNT_EN: 70000 pushes to B -> cnt_b = 70000 mod 65536 = 4464, cnt_a = 0.
